// File: rtl/adc_spi_reg_responder.sv
// SPI mode-0 responder emulating an ADC register bank. Pins are oversampled in the CLK domain,
// and 16-bit R/W frames are decoded into writes and MISO read-back of a NUM_REGS x 8 bank.
module adc_spi_reg_responder #(
    parameter int NUM_REGS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SPI_SCLK_IN,
    input  logic       SPI_MOSI_IN,
    input  logic       SPI_CSN_IN,
    input  logic       SPI_RSTN_IN,
    output logic       SPI_MISO_OUT,
    output logic       REG_WR_STB,
    output logic [6:0] REG_WR_ADDR,
    output logic [7:0] REG_WR_DATA,
    input  logic [6:0] HOST_RD_ADDR,
    output logic [7:0] HOST_RD_DATA,
    output logic       FRAME_ERR
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync, rstn_sync;
    logic sclk_d, csn_d;
    logic sclk_s, mosi_s, csn_s, rstn_s;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic soft_rst;

    state_t      state, state_next;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic [13:0] shift, shift_next;
    logic [6:0]  tx, tx_next;
    logic        miso, miso_next;
    logic        is_read, is_read_next;
    logic        extra, extra_next;
    logic        wr_en, err_pulse;

    logic [7:0] regs [NUM_REGS];
    logic [6:0] cmd_addr, wr_addr;
    logic [7:0] wr_data, cmd_rd_val, host_val;

    function automatic logic addr_ok(input logic [6:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // Edge registers track the pins through an RSTN reset so releasing RSTN mid-frame
    // cannot fabricate a CSN falling event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            csn_sync  <= '1;
            rstn_sync <= '1;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK_IN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI_IN};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN_IN};
            rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], SPI_RSTN_IN};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign rstn_s    = rstn_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d & ~csn_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~csn_s;
    assign csn_fall  = ~csn_s & csn_d;
    assign csn_rise  = csn_s & ~csn_d;
    assign soft_rst  = RST | ~rstn_s;

    assign cmd_addr   = {shift[5:0], mosi_s};
    assign wr_addr    = shift[13:7];
    assign wr_data    = {shift[6:0], mosi_s};
    assign cmd_rd_val = addr_ok(cmd_addr) ? regs[cmd_addr[IDX_W-1:0]] : 8'h00;
    assign host_val   = addr_ok(HOST_RD_ADDR) ? regs[HOST_RD_ADDR[IDX_W-1:0]] : 8'h00;

    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= '0;
            miso    <= 1'b0;
            is_read <= 1'b0;
            extra   <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            tx      <= tx_next;
            miso    <= miso_next;
            is_read <= is_read_next;
            extra   <= extra_next;
        end
    end

    // Shift only keeps the 14 most recent bits; the incoming MOSI bit completes each field.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        tx_next      = tx;
        miso_next    = miso;
        is_read_next = is_read;
        extra_next   = extra;
        wr_en        = 1'b0;
        err_pulse    = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_next   = CMD;
                    is_read_next = 1'b0;
                    extra_next   = 1'b0;
                    miso_next    = 1'b0;
                    if (sclk_rise) begin
                        shift_next   = {13'd0, mosi_s};
                        bit_cnt_next = 5'd1;
                    end else begin
                        shift_next   = '0;
                        bit_cnt_next = 5'd0;
                    end
                end
            end
            CMD: begin
                if (csn_rise) begin
                    state_next = IDLE;
                    err_pulse  = 1'b1;
                end else if (sclk_rise) begin
                    shift_next   = {shift[12:0], mosi_s};
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        state_next   = DATA;
                        is_read_next = shift[6];
                        if (shift[6]) begin
                            tx_next   = cmd_rd_val[6:0];
                            miso_next = cmd_rd_val[7];
                        end
                    end
                end
            end
            DATA: begin
                if (csn_rise) begin
                    state_next = IDLE;
                    err_pulse  = 1'b1;
                    miso_next  = 1'b0;
                end else if (sclk_rise) begin
                    shift_next   = {shift[12:0], mosi_s};
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        state_next = DONE;
                        wr_en      = ~is_read & addr_ok(wr_addr);
                    end
                end else if (sclk_fall && is_read && bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                    tx_next   = {tx[5:0], 1'b0};
                    miso_next = tx[6];
                end
            end
            DONE: begin
                if (csn_rise) begin
                    state_next = IDLE;
                    err_pulse  = extra;
                    miso_next  = 1'b0;
                end else if (sclk_rise) begin
                    extra_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bank and local read share the edge, so a same-cycle host read still sees the old value.
    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            REG_WR_STB   <= 1'b0;
            REG_WR_ADDR  <= 7'd0;
            REG_WR_DATA  <= 8'h00;
            HOST_RD_DATA <= 8'h00;
            FRAME_ERR    <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wr_addr[IDX_W-1:0]] <= wr_data;
                REG_WR_ADDR              <= wr_addr;
                REG_WR_DATA              <= wr_data;
            end
            REG_WR_STB   <= wr_en;
            HOST_RD_DATA <= host_val;
            FRAME_ERR    <= err_pulse;
        end
    end

    assign SPI_MISO_OUT = miso;

endmodule

// File: tb/tb_adc_spi_reg_responder.sv
// Scenario bench for adc_spi_reg_responder: a host model bit-bangs SPI at CLK/8 while a
// scoreboard matches every write strobe against the queue of expected commits.
module tb_adc_spi_reg_responder;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, csn, rstn;
    logic       miso, wr_stb, frame_err;
    logic [6:0] wr_addr, hrd_addr;
    logic [7:0] wr_data, hrd_data;

    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    int err_count = 0;

    logic [14:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  hrd_at_stb = 8'h00;
    logic [7:0]  hrd_after_stb = 8'h00;
    logic        capture_next = 1'b0;

    adc_spi_reg_responder #(.NUM_REGS(32), .SYNC_STAGES(2)) dut (
        .CLK(clk),
        .RST(rst),
        .SPI_SCLK_IN(sclk),
        .SPI_MOSI_IN(mosi),
        .SPI_CSN_IN(csn),
        .SPI_RSTN_IN(rstn),
        .SPI_MISO_OUT(miso),
        .REG_WR_STB(wr_stb),
        .REG_WR_ADDR(wr_addr),
        .REG_WR_DATA(wr_data),
        .HOST_RD_ADDR(hrd_addr),
        .HOST_RD_DATA(hrd_data),
        .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Write scoreboard: every strobe must match the oldest expected commit.
    initial begin
        forever begin
            @(negedge clk);
            if (capture_next) begin
                hrd_after_stb = hrd_data;
                capture_next  = 1'b0;
            end
            if (wr_stb) begin
                stb_count++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got addr=%h data=%h, expected no strobe", wr_addr, wr_data);
                end else begin
                    logic [14:0] e;
                    e = exp_wr.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("[TB] FAIL strobe_payload: got addr=%h data=%h, expected addr=%h data=%h",
                                 wr_addr, wr_data, e[14:8], e[7:0]);
                    end
                end
                hrd_at_stb   = hrd_data;
                capture_next = 1'b1;
            end
            if (frame_err) err_count++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_read(input logic [6:0] a, output logic [7:0] v);
        hrd_addr = a;
        wait_clk(1);
        v = hrd_data;
    endtask

    // Host SPI frame; bits beyond 16 send 0, rstn_bit >= 0 pulses RSTN before that bit.
    task automatic spi_xfer(input logic [15:0] word, input int nbits, input int rstn_bit,
                            output logic [15:0] rx);
        rx  = '0;
        csn = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b0;
            if (i == rstn_bit) begin
                rstn = 1'b0;
                wait_clk(10);
                rstn = 1'b1;
            end
            wait_clk(HALF);
            if (i < 16) rx[15-i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        csn  = 1'b1;
        mosi = 1'b0;
        wait_clk(3 * HALF);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; csn = 1'b1; rstn = 1'b1; hrd_addr = 7'd0;
        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        checks++;
        if ({miso, wr_stb, frame_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got miso/stb/err=%b, expected 000", {miso, wr_stb, frame_err});
        end
        checks++;
        if ({wr_addr, wr_data} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_wr_bus: got addr=%h data=%h, expected 0", wr_addr, wr_data);
        end
        checks++;
        if (hrd_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_host_rd: got %h, expected 00", hrd_data);
        end
        host_read(7'h0A, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_reg0A: got %h, expected 00", v);
        end
    endtask

    task automatic test_write();
        logic [15:0] rx;
        logic [7:0]  v;
        int s0, e0;
        s0 = stb_count; e0 = err_count;
        hrd_addr = 7'h0A;
        exp_wr.push_back({7'h0A, 8'h5A});
        spi_xfer(16'h0A5A, 16, -1, rx);
        checks++;
        if (stb_count - s0 !== 1) begin
            errors++;
            $display("[TB] FAIL write_strobe_count: got %0d, expected 1", stb_count - s0);
        end
        checks++;
        if (hrd_at_stb !== 8'h00 || hrd_after_stb !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL write_host_timing: got at=%h after=%h, expected at=00 after=5A", hrd_at_stb, hrd_after_stb);
        end
        host_read(7'h0A, v);
        checks++;
        if (v !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL write_readback: got %h, expected 5A", v);
        end
        checks++;
        if (err_count !== e0) begin
            errors++;
            $display("[TB] FAIL write_no_err: got %0d pulses, expected 0", err_count - e0);
        end
    endtask

    task automatic test_read();
        logic [15:0] rx;
        logic [7:0]  e;
        int s0;
        s0 = stb_count;
        exp_rd.push_back(8'h5A);
        spi_xfer(16'h8A00, 16, -1, rx);
        e = exp_rd.pop_front();
        checks++;
        if (rx[7:0] !== e) begin
            errors++;
            $display("[TB] FAIL read_data: got %h, expected %h", rx[7:0], e);
        end
        checks++;
        if (rx[15:8] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL read_miso_cmd: got %h, expected 00", rx[15:8]);
        end
        checks++;
        if (stb_count !== s0) begin
            errors++;
            $display("[TB] FAIL read_no_strobe: got %0d strobes, expected 0", stb_count - s0);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] rx;
        logic [7:0]  e;
        exp_wr.push_back({7'h1F, 8'h81});
        spi_xfer(16'h1F81, 16, -1, rx);
        exp_wr.push_back({7'h00, 8'hC3});
        spi_xfer(16'h00C3, 16, -1, rx);
        exp_rd.push_back(8'h81);
        spi_xfer(16'h9F00, 16, -1, rx);
        e = exp_rd.pop_front();
        checks++;
        if (rx[7:0] !== e) begin
            errors++;
            $display("[TB] FAIL pattern_read_1F: got %h, expected %h", rx[7:0], e);
        end
        exp_rd.push_back(8'hC3);
        spi_xfer(16'h80FF, 16, -1, rx);
        e = exp_rd.pop_front();
        checks++;
        if (rx[7:0] !== e) begin
            errors++;
            $display("[TB] FAIL pattern_read_00: got %h, expected %h", rx[7:0], e);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] rx;
        logic [7:0]  v;
        int s0, e0;
        s0 = stb_count; e0 = err_count;
        spi_xfer(16'h0B77, 11, -1, rx);
        checks++;
        if (err_count - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL short_err_pulse: got %0d pulses, expected 1", err_count - e0);
        end
        checks++;
        if (stb_count !== s0) begin
            errors++;
            $display("[TB] FAIL short_no_strobe: got %0d strobes, expected 0", stb_count - s0);
        end
        host_read(7'h0B, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL short_reg_kept: got %h, expected 00", v);
        end
        exp_wr.push_back({7'h0B, 8'h77});
        spi_xfer(16'h0B77, 16, -1, rx);
        host_read(7'h0B, v);
        checks++;
        if (v !== 8'h77 || err_count - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL short_recovery: got reg=%h errs=%0d, expected reg=77 errs=1", v, err_count - e0);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rx;
        logic [7:0]  e;
        int s0, e0;
        s0 = stb_count; e0 = err_count;
        spi_xfer(16'h7F33, 16, -1, rx);
        spi_xfer(16'h2055, 16, -1, rx);
        checks++;
        if (stb_count !== s0 || err_count !== e0) begin
            errors++;
            $display("[TB] FAIL oor_write: got strobes=%0d errs=%0d, expected 0 and 0", stb_count - s0, err_count - e0);
        end
        exp_rd.push_back(8'h00);
        spi_xfer(16'hFF00, 16, -1, rx);
        e = exp_rd.pop_front();
        checks++;
        if (rx !== {8'h00, e}) begin
            errors++;
            $display("[TB] FAIL oor_read_7F: got %h, expected %h", rx, {8'h00, e});
        end
        exp_rd.push_back(8'h00);
        spi_xfer(16'hA0FF, 16, -1, rx);
        e = exp_rd.pop_front();
        checks++;
        if (rx[7:0] !== e) begin
            errors++;
            $display("[TB] FAIL oor_read_20: got %h, expected %h", rx[7:0], e);
        end
    endtask

    task automatic test_rstn();
        logic [15:0] rx;
        logic [7:0]  v;
        logic [7:0]  vals [3];
        int s0, e0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({7'(i + 1), vals[i]});
            spi_xfer({1'b0, 7'(i + 1), vals[i]}, 16, -1, rx);
        end
        host_read(7'd2, v);
        checks++;
        if (v !== 8'h22) begin
            errors++;
            $display("[TB] FAIL rstn_pre_write: got %h, expected 22", v);
        end
        rstn = 1'b0;
        wait_clk(10);
        rstn = 1'b1;
        wait_clk(4);
        checks++;
        if ({wr_addr, wr_data} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL rstn_wr_bus: got addr=%h data=%h, expected 0", wr_addr, wr_data);
        end
        for (int i = 1; i <= 3; i++) begin
            host_read(7'(i), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("[TB] FAIL rstn_reg_clear: reg %0d got %h, expected 00", i, v);
            end
        end
        s0 = stb_count; e0 = err_count;
        spi_xfer(16'h0444, 16, 5, rx);
        host_read(7'd4, v);
        checks++;
        if (stb_count !== s0 || err_count !== e0 || v !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rstn_midframe: got strobes=%0d errs=%0d reg=%h, expected 0 0 00",
                     stb_count - s0, err_count - e0, v);
        end
        exp_wr.push_back({7'd4, 8'h66});
        spi_xfer(16'h0466, 16, -1, rx);
        host_read(7'd4, v);
        checks++;
        if (v !== 8'h66) begin
            errors++;
            $display("[TB] FAIL rstn_recovery: got %h, expected 66", v);
        end
    endtask

    task automatic test_extra_edge();
        logic [15:0] rx;
        logic [7:0]  v;
        int s0, e0;
        s0 = stb_count; e0 = err_count;
        exp_wr.push_back({7'h05, 8'hA7});
        spi_xfer(16'h05A7, 17, -1, rx);
        checks++;
        if (stb_count - s0 !== 1 || err_count - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL extra_edge_counts: got strobes=%0d errs=%0d, expected 1 and 1",
                     stb_count - s0, err_count - e0);
        end
        host_read(7'h05, v);
        checks++;
        if (v !== 8'hA7) begin
            errors++;
            $display("[TB] FAIL extra_edge_reg: got %h, expected A7", v);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_patterns();
        test_short_frame();
        test_out_of_range();
        test_rstn();
        test_extra_edge();
        wait_clk(4);
        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_writes: got %0d commits outstanding, expected 0", exp_wr.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
